vc_input_stage: RTL and testbench
=================================

Name: vc_input_stage

Overview:
- Parametrised successor to the two-VC initial-logic stage.
- Classifies each incoming word by a class field in its upper bits and pushes it into one of NUM_VC per-channel FIFOs.
- Exposes per-VC pop, status flags, back-pressure (pause), sticky error and registered read data with a valid strobe.
- Sits at the head of the transmit path, feeding the VC arbiter.

Parameters:
- DATA_WIDTH, 6: width of data_in and of each FIFO word.
- NUM_VC, 4: number of virtual channels; power of two, >=2.
- ADDR_WIDTH, 2: FIFO address bits; depth DEPTH = 2**ADDR_WIDTH.
- AF_TH, 3: almost_full asserted when count >= AF_TH (1..DEPTH-1).
- AE_TH, 1: almost_empty asserted when 1 <= count <= AE_TH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_enable  in  1  push data_in this cycle.
- data_in  in  DATA_WIDTH  word; VC index = data_in[DATA_WIDTH-1 -: VC_W], VC_W = clog2(NUM_VC).
- pop  in  NUM_VC  per-VC pop request.
- data_out  out  NUM_VC*DATA_WIDTH  VC i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  NUM_VC  data_out slice i is valid this cycle.
- full  out  NUM_VC  count == DEPTH.
- empty  out  NUM_VC  count == 0.
- almost_full  out  NUM_VC  count >= AF_TH.
- almost_empty  out  NUM_VC  1 <= count <= AE_TH.
- pause  out  NUM_VC  almost_full | full; upstream must stop sending to that VC.
- error  out  NUM_VC  sticky overflow/underflow flag per VC.

Behaviour:
- Reset (reset==0 at posedge):
  - all counts and pointers are 0; data_out is 0.
  - valid_out, full, almost_full, almost_empty, pause and error are 0; empty is all 1s.
  - Reset applied mid-operation discards the FIFO contents and any in-flight pop.
- Routing: on wr_enable, only the VC selected by data_in's class field is written. The full word, class bits included, is stored.
- Push: VC not full -> mem[wr_ptr] <= data_in, wr_ptr++, count++.
- Overflow: VC full and no same-cycle pop on that VC -> word dropped, error[i] <= 1.
- Pop: pop[i] with VC i not empty -> data_out slice <= mem[rd_ptr], rd_ptr++, count--, valid_out[i] = 1 in the next cycle.
  - Latency is 1 cycle.
  - valid_out is a one-cycle pulse per pop.
  - data_out holds its last value when no pop occurs.
- Underflow: pop[i] on an empty VC -> no pointer change, valid_out[i] stays 0, error[i] <= 1.
- Simultaneous push and pop on the same VC:
  - Both are performed and count is unchanged. This includes the full case: the pop frees the slot, so there is no overflow.
  - On an empty VC, the pop is an underflow and the push succeeds; no bypass path exists.
- Pops on different VCs are independent. All VCs may pop in the same cycle.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. count is ADDR_WIDTH+1 bits and saturates at 0..DEPTH.
- Flags are decoded from the registered count and reflect the state after the last edge.
- error is sticky and is cleared only by reset.

Decomposition:
- Shared package vc_pkg holds:
  - the VC_W = $clog2(NUM_VC) helper;
  - the vc_status struct typedef {full, empty, almost_full, almost_empty, pause, error};
  - default width and threshold constants shared with the arbiter.
- Sub-module vc_fifo: one parametrised synchronous FIFO (DATA_WIDTH, ADDR_WIDTH, AF_TH, AE_TH) with push/pop/flags/error and registered read port.
  - Top level is a class decoder plus a generate loop of NUM_VC vc_fifo instances.

Test Plan:
1. Reset, then write 0x05 (VC0), 0x12 (VC1), 0x2A (VC2), 0x3F (VC3); pop all four together -> one cycle later valid_out=4'b1111 and slices 0x05/0x12/0x2A/0x3F, all empty=1, error=0.
2. Push 0x01..0x03 into VC0 -> pause[0]=almost_full[0]=1 after the third push. 4th push 0x04 -> full[0]=1. 5th push 0x05 -> dropped, error[0]=1. Four pops return 0x01..0x04.
3. VC1 full (0x10..0x13): push 0x14 and pop[1] in the same cycle -> data_out VC1=0x10, count stays 4, error[1]=0. Subsequent pops yield 0x11, 0x12, 0x13, 0x14.
4. pop[2] on empty VC2 -> valid_out[2]=0, error[2]=1, other VCs unaffected; error[2] remains 1 until reset.
5. Wrap-around: 10 cycles of push+pop alternating on VC3 with data 0x30..0x39 -> output order preserved across pointer wrap; almost_empty[3]=1 whenever count==1.
6. Reset asserted with VC0 holding 3 words and pop[0] active -> next cycle empty[0]=1, valid_out=0, error=0, data_out=0.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared types and defaults for the virtual-channel input stage and arbiter.
package vc_pkg;

    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_NUM_VC     = 4;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_AF_TH      = 3;
    localparam int DEF_AE_TH      = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic pause;
        logic error;
    } vc_status_t;

    // Width of the class field that selects a channel.
    function automatic int vc_w(input int num_vc);
        return $clog2(num_vc);
    endfunction

endpackage

// File: rtl/vc_input_stage_if.sv
// Upstream/downstream bundle of the VC input stage: push, per-VC pop, read data and flags.
interface vc_input_stage_if #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_VC     = 4
);

    logic                         wr_enable;
    logic [DATA_WIDTH-1:0]        data_in;
    logic [NUM_VC-1:0]            pop;
    logic [NUM_VC*DATA_WIDTH-1:0] data_out;
    logic [NUM_VC-1:0]            valid_out;
    logic [NUM_VC-1:0]            full;
    logic [NUM_VC-1:0]            empty;
    logic [NUM_VC-1:0]            almost_full;
    logic [NUM_VC-1:0]            almost_empty;
    logic [NUM_VC-1:0]            pause;
    logic [NUM_VC-1:0]            error;

    modport master (
        output wr_enable, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, pause, error
    );

    modport slave (
        input  wr_enable, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty, pause, error
    );

endinterface

// File: rtl/vc_fifo.sv
// Single-channel synchronous FIFO with registered read port, occupancy flags and sticky error.
module vc_fifo
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_TH      = DEF_AF_TH,
    parameter int AE_TH      = DEF_AE_TH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output vc_status_t            status
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  error_q;

    logic is_full;
    logic is_empty;
    logic pop_ok;
    logic push_ok;
    logic fault;

    always_comb begin
        is_full  = (count == DEPTH_C);
        is_empty = (count == '0);
        pop_ok   = pop && !is_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_ok  = push && (!is_full || pop_ok);
        fault    = (push && is_full && !pop) || (pop && is_empty);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fault) begin
                error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        status.full         = is_full;
        status.empty        = is_empty;
        status.almost_full  = (count >= AF_C);
        status.almost_empty = !is_empty && (count <= AE_C);
        status.pause        = (count >= AF_C) || is_full;
        status.error        = error_q;
    end

endmodule

// File: rtl/vc_input_stage.sv
// Transmit-path head: steers each word by its class field into one of NUM_VC FIFOs.
module vc_input_stage
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_VC     = DEF_NUM_VC,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_TH      = DEF_AF_TH,
    parameter int AE_TH      = DEF_AE_TH
) (
    input  logic              clk,
    input  logic              reset,
    vc_input_stage_if.slave   bus
);

    localparam int VC_W = vc_w(NUM_VC);

    logic [VC_W-1:0]   vc_sel;
    vc_status_t        st [NUM_VC];

    assign vc_sel = bus.data_in[DATA_WIDTH-1 -: VC_W];

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        localparam logic [VC_W-1:0] IDX = VC_W'(i);
        logic push;

        assign push = bus.wr_enable && (vc_sel == IDX);

        vc_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .AF_TH      (AF_TH),
            .AE_TH      (AE_TH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push   (push),
            .pop    (bus.pop[i]),
            .din    (bus.data_in),
            .dout   (bus.data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .valid  (bus.valid_out[i]),
            .status (st[i])
        );

        assign bus.full[i]         = st[i].full;
        assign bus.empty[i]        = st[i].empty;
        assign bus.almost_full[i]  = st[i].almost_full;
        assign bus.almost_empty[i] = st[i].almost_empty;
        assign bus.pause[i]        = st[i].pause;
        assign bus.error[i]        = st[i].error;
    end

endmodule

// File: tb/tb_vc_input_stage.sv
// Directed bench for vc_input_stage: routing, flags, overflow/underflow, wrap and reset.
module tb_vc_input_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vc_input_stage_if #(.DATA_WIDTH(6), .NUM_VC(4)) bus ();

    vc_input_stage #(
        .DATA_WIDTH (6),
        .NUM_VC     (4),
        .ADDR_WIDTH (2),
        .AF_TH      (3),
        .AE_TH      (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge and are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [5:0] d);
        bus.wr_enable = 1'b1;
        bus.data_in   = d;
        step();
        bus.wr_enable = 1'b0;
    endtask

    task automatic pop_vc(input logic [3:0] p);
        bus.pop = p;
        step();
        bus.pop = 4'b0000;
    endtask

    initial begin
        logic [5:0] exp_d;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.wr_enable = 1'b0;
        bus.data_in   = '0;
        bus.pop       = '0;
        step();
        step();
        chk("rst_empty", 32'(bus.empty), 32'hF);
        chk("rst_valid", 32'(bus.valid_out), 32'h0);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_af", 32'(bus.almost_full), 32'h0);
        chk("rst_ae", 32'(bus.almost_empty), 32'h0);
        chk("rst_pause", 32'(bus.pause), 32'h0);
        chk("rst_error", 32'(bus.error), 32'h0);
        chk("rst_dout", 32'(bus.data_out), 32'h0);
        reset = 1'b1;
        step();

        // 1: one word per VC, pop all together
        push_word(6'h05);
        push_word(6'h12);
        push_word(6'h2A);
        push_word(6'h3F);
        chk("t1_empty_before", 32'(bus.empty), 32'h0);
        chk("t1_ae_before", 32'(bus.almost_empty), 32'hF);
        pop_vc(4'b1111);
        chk("t1_valid", 32'(bus.valid_out), 32'hF);
        chk("t1_dout", 32'(bus.data_out), 32'({6'h3F, 6'h2A, 6'h12, 6'h05}));
        chk("t1_empty", 32'(bus.empty), 32'hF);
        chk("t1_error", 32'(bus.error), 32'h0);
        step();
        chk("t1_valid_pulse", 32'(bus.valid_out), 32'h0);
        chk("t1_dout_hold", 32'(bus.data_out), 32'({6'h3F, 6'h2A, 6'h12, 6'h05}));

        // 2: fill VC0, overflow, drain
        push_word(6'h01);
        push_word(6'h02);
        chk("t2_af_at2", 32'(bus.almost_full[0]), 32'h0);
        push_word(6'h03);
        chk("t2_af_at3", 32'(bus.almost_full[0]), 32'h1);
        chk("t2_pause_at3", 32'(bus.pause), 32'h1);
        chk("t2_full_at3", 32'(bus.full[0]), 32'h0);
        push_word(6'h04);
        chk("t2_full_at4", 32'(bus.full), 32'h1);
        chk("t2_err_at4", 32'(bus.error), 32'h0);
        push_word(6'h05);
        chk("t2_err_ovf", 32'(bus.error), 32'h1);
        chk("t2_full_ovf", 32'(bus.full), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            pop_vc(4'b0001);
            exp_d = 6'(k);
            chk("t2_pop_data", 32'(bus.data_out[5:0]), 32'(exp_d));
            chk("t2_pop_valid", 32'(bus.valid_out), 32'h1);
            if (k == 3) chk("t2_ae_at1", 32'(bus.almost_empty[0]), 32'h1);
        end
        chk("t2_empty_end", 32'(bus.empty[0]), 32'h1);

        // 3: push and pop together on a full VC1
        push_word(6'h10);
        push_word(6'h11);
        push_word(6'h12);
        push_word(6'h13);
        chk("t3_full", 32'(bus.full[1]), 32'h1);
        bus.pop = 4'b0010;
        push_word(6'h14);
        bus.pop = 4'b0000;
        chk("t3_dout", 32'(bus.data_out[11:6]), 32'h10);
        chk("t3_valid", 32'(bus.valid_out), 32'h2);
        chk("t3_still_full", 32'(bus.full[1]), 32'h1);
        chk("t3_no_err", 32'(bus.error[1]), 32'h0);
        for (int k = 0; k < 4; k++) begin
            pop_vc(4'b0010);
            exp_d = 6'h11 + 6'(k);
            chk("t3_pop_data", 32'(bus.data_out[11:6]), 32'(exp_d));
        end
        chk("t3_empty_end", 32'(bus.empty[1]), 32'h1);

        // 4: underflow on VC2
        pop_vc(4'b0100);
        chk("t4_valid", 32'(bus.valid_out), 32'h0);
        chk("t4_error", 32'(bus.error), 32'h5);
        chk("t4_dout_hold", 32'(bus.data_out[17:12]), 32'h2A);
        chk("t4_empty", 32'(bus.empty), 32'hF);
        step();
        step();
        chk("t4_sticky", 32'(bus.error), 32'h5);

        // 5: alternate push/pop on VC3 across pointer wrap
        for (int k = 0; k < 10; k++) begin
            exp_d = 6'h30 + 6'(k);
            push_word(exp_d);
            chk("t5_ae", 32'(bus.almost_empty[3]), 32'h1);
            pop_vc(4'b1000);
            chk("t5_data", 32'(bus.data_out[23:18]), 32'(exp_d));
            chk("t5_valid", 32'(bus.valid_out), 32'h8);
        end
        chk("t5_empty", 32'(bus.empty[3]), 32'h1);

        // 6: reset with contents and an in-flight pop
        push_word(6'h01);
        push_word(6'h02);
        push_word(6'h03);
        chk("t6_af", 32'(bus.almost_full[0]), 32'h1);
        bus.pop = 4'b0001;
        reset   = 1'b0;
        step();
        bus.pop = 4'b0000;
        chk("t6_empty", 32'(bus.empty), 32'hF);
        chk("t6_valid", 32'(bus.valid_out), 32'h0);
        chk("t6_error", 32'(bus.error), 32'h0);
        chk("t6_dout", 32'(bus.data_out), 32'h0);
        chk("t6_af_clr", 32'(bus.almost_full), 32'h0);
        reset = 1'b1;
        step();
        pop_vc(4'b0001);
        chk("t6_discarded", 32'(bus.valid_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
